mux32_2to1: RTL and testbench

//   32-bit two-input word selector for datapath operand steering.
//   - out: zero-latency combinational path.
//   - out_q: registered copy of out.
//   - sel_cnt: counts changes of sel.

---
 rtl/mux32_pkg.sv | 10 +
 rtl/mux32_sel_cnt.sv | 35 +++
 rtl/mux32_2to1.sv | 52 +++++
 tb/tb_mux32_2to1.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mux32_pkg.sv
// Shared constants and types for the 32-bit two-input word selector.
package mux32_pkg;
  localparam int WIDTH_DEF     = 32;
  localparam int CNT_WIDTH_DEF = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/mux32_sel_cnt.sv
// Select-change counter: saturating count of sel transitions.
// Updates one cycle after a sel change; no backpressure, counter holds at all-ones.
module mux32_sel_cnt
  import mux32_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel,
  output logic [CNT_WIDTH-1:0] sel_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic sel_d;
  logic sel_chg;
  logic cnt_sat;

  assign sel_chg = sel ^ sel_d;
  assign cnt_sat = &sel_cnt;

  // sel_d resets to SEL_A, so a first edge with sel=1 counts as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_d   <= SEL_A;
      sel_cnt <= '0;
    end else begin
      sel_d <= sel;
      if (sel_chg && !cnt_sat)
        sel_cnt <= sel_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/mux32_2to1.sv
// Two-input word selector: combinational out, 1-cycle registered out_q, sel change counter; no backpressure.
// Optional even-parity output out_par registered with out_q when MUX32_PARITY_EN is defined.
module mux32_2to1
  import mux32_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 sel,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic [CNT_WIDTH-1:0] sel_cnt
`ifdef MUX32_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  // Combinational path stays live through reset.
  assign out = (sel == SEL_B) ? B : A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_q <= '0;
    else
      out_q <= out;
  end

`ifdef MUX32_PARITY_EN
  // Computed from out so it lands on the same edge as out_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_par <= 1'b0;
    else
      out_par <= ^out;
  end
`endif

  mux32_sel_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sel_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .sel_cnt (sel_cnt)
  );

endmodule

// File: tb/tb_mux32_2to1.sv
// Directed bench for mux32_2to1: combinational select, registered copy, sel counter, reset, optional parity.
module tb_mux32_2to1;
  import mux32_pkg::*;

  logic        clk;
  logic        rst_n;
  word_t       A;
  word_t       B;
  logic        sel;
  word_t       out;
  word_t       out_q;
  logic [15:0] sel_cnt;
`ifdef MUX32_PARITY_EN
  logic        out_par;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mux32_2to1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .sel_cnt (sel_cnt)
`ifdef MUX32_PARITY_EN
    ,
    .out_par (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    A     = '0;
    B     = '0;
    sel   = 1'b0;
    #1;
    chk("rst_out",     out,     32'h0);
    chk("rst_out_q",   out_q,   32'h0);
    chk("rst_sel_cnt", {16'h0, sel_cnt}, 32'h0);
`ifdef MUX32_PARITY_EN
    chk("rst_out_par", {31'h0, out_par}, 32'h0);
`endif
    step();
    step();
    chk("rst_hold_out_q", out_q, 32'h0);
    rst_n = 1'b1;

    // A selected: out immediate, out_q one edge later
    A = 32'hFFFF_FFFF;
    #1;
    chk("a_out_now",   out,   32'hFFFF_FFFF);
    chk("a_out_q_old", out_q, 32'h0);
    step();
    chk("a_out_q",     out_q, 32'hFFFF_FFFF);
    chk("a_sel_cnt",   {16'h0, sel_cnt}, 32'h0);

    // sel 0->1 then 1->0
    sel = 1'b1;
    #1;
    chk("b_out_now",   out,   32'h0);
    chk("b_out_q_old", out_q, 32'hFFFF_FFFF);
    step();
    chk("b_out_q",     out_q, 32'h0);
    chk("b_sel_cnt",   {16'h0, sel_cnt}, 32'd1);
    sel = 1'b0;
    #1;
    chk("a2_out_now",  out,   32'hFFFF_FFFF);
    step();
    chk("a2_sel_cnt",  {16'h0, sel_cnt}, 32'd2);
    chk("a2_out_q",    out_q, 32'hFFFF_FFFF);

    // distinct A/B words
    A   = 32'h1234_5678;
    B   = 32'h9ABC_DEF0;
    sel = 1'b1;
    #1;
    chk("mix_out_b",   out,   32'h9ABC_DEF0);
    step();
    chk("mix_out_q",   out_q, 32'h9ABC_DEF0);
    chk("mix_sel_cnt", {16'h0, sel_cnt}, 32'd3);
    step();
    chk("hold_sel_cnt", {16'h0, sel_cnt}, 32'd3);
    sel = 1'b0;
    #1;
    chk("mix_out_a",   out,   32'h1234_5678);
    step();
    chk("mix_sel_cnt4", {16'h0, sel_cnt}, 32'd4);

    // 65531 more changes reach exactly all-ones
    for (int i = 0; i < 65531; i++) begin
      sel = ~sel;
      step();
    end
    chk("cnt_at_max",  {16'h0, sel_cnt}, 32'h0000_FFFF);
    for (int i = 0; i < 4465; i++) begin
      sel = ~sel;
      step();
    end
    chk("cnt_saturated", {16'h0, sel_cnt}, 32'h0000_FFFF);

    // asynchronous reset mid-cycle
    A   = 32'hFFFF_FFFF;
    sel = 1'b0;
    step();
    step();
    chk("pre_rst_out_q", out_q, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_q",   out_q, 32'h0);
    chk("async_sel_cnt", {16'h0, sel_cnt}, 32'h0);
    chk("async_out",     out,   32'hFFFF_FFFF);
    B   = 32'h5555_AAAA;
    sel = 1'b1;
    #1;
    chk("rst_out_track", out,   32'h5555_AAAA);
    step();
    chk("rst_edge_out_q", out_q, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rel_sel_cnt",   {16'h0, sel_cnt}, 32'd1);
    chk("rel_out_q",     out_q, 32'h5555_AAAA);

`ifdef MUX32_PARITY_EN
    A   = 32'h0000_0001;
    sel = 1'b0;
    step();
    chk("par_odd",  {31'h0, out_par}, 32'd1);
    A = 32'h0000_0003;
    #1;
    chk("par_lag",  {31'h0, out_par}, 32'd1);
    step();
    chk("par_even", {31'h0, out_par}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
